// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV64M multiply/divide sequencer, one bit per cycle
module mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [12:0]     in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [5:0]     cnt;
    logic [12:0]    op_q;
    logic           neg_q, neg_r;
    logic [127:0]   acc, mcand;
    logic [63:0]    mplier, rem_q, quo_q, dsor;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Accept-time decode of the incoming operation
    logic        op_ok, a_mul, a_w, a_rem, a_s1, a_s2, neg1, neg2;
    logic        div0, ovf, special, accept;
    logic [63:0] op1, op2, mag1, mag2, spec_result;

    always_comb begin
        op_ok = (in_op != 13'd0) && ((in_op & (in_op - 13'd1)) == 13'd0);
        a_mul = |in_op[4:0];
        a_w   = in_op[4] | in_op[9] | in_op[10] | in_op[11] | in_op[12];
        a_rem = in_op[7] | in_op[8] | in_op[11] | in_op[12];
        a_s2  = in_op[1] | in_op[5] | in_op[7] | in_op[9] | in_op[11];
        a_s1  = a_s2 | in_op[2];
        op1   = a_w ? (a_s1 ? sext32(in_src1[31:0]) : {32'd0, in_src1[31:0]}) : in_src1;
        op2   = a_w ? (a_s2 ? sext32(in_src2[31:0]) : {32'd0, in_src2[31:0]}) : in_src2;
        neg1  = a_s1 & op1[63];
        neg2  = a_s2 & op2[63];
        mag1  = neg1 ? (~op1 + 64'd1) : op1;
        mag2  = neg2 ? (~op2 + 64'd1) : op2;
        div0  = ~a_mul && (op2 == 64'd0);
        ovf   = ~a_mul && a_s2 && (op2 == {64{1'b1}}) &&
                (op1 == (a_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special = div0 | ovf;
        if (div0)
            spec_result = a_rem ? (a_w ? sext32(in_src1[31:0]) : in_src1) : {64{1'b1}};
        else
            spec_result = a_rem ? 64'd0 : op1;
    end

    // One iteration of shift-add multiply and restoring divide
    logic [127:0] acc_nxt, prod;
    logic [64:0]  trial, diff;
    logic [63:0]  rem_nxt, quo_nxt, qf, rf, final_result;

    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        trial   = {rem_q, quo_q[63]};
        diff    = trial - {1'b0, dsor};
        rem_nxt = diff[64] ? trial[63:0] : diff[63:0];
        quo_nxt = {quo_q[62:0], ~diff[64]};
        prod    = neg_q ? (~acc_nxt + 128'd1) : acc_nxt;
        qf      = neg_q ? (~quo_nxt + 64'd1) : quo_nxt;
        rf      = neg_r ? (~rem_nxt + 64'd1) : rem_nxt;
        if (op_q[0])
            final_result = prod[63:0];
        else if (op_q[1] | op_q[2] | op_q[3])
            final_result = prod[127:64];
        else if (op_q[4])
            final_result = sext32(prod[31:0]);
        else if (op_q[5] | op_q[6])
            final_result = qf;
        else if (op_q[7] | op_q[8])
            final_result = rf;
        else if (op_q[9] | op_q[10])
            final_result = sext32(qf[31:0]);
        else if (op_q[11] | op_q[12])
            final_result = sext32(rf[31:0]);
        else
            final_result = 64'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && op_ok && !flush) begin
                    accept    = 1'b1;
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: if (cnt == 6'd0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 6'd0;
            op_q       <= 13'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            acc        <= 128'd0;
            mcand      <= 128'd0;
            mplier     <= 64'd0;
            rem_q      <= 64'd0;
            quo_q      <= 64'd0;
            dsor       <= 64'd0;
            out_result <= 64'd0;
        end else if (accept) begin
            cnt    <= a_w ? 6'd31 : 6'd63;
            op_q   <= in_op;
            neg_q  <= neg1 ^ neg2;
            neg_r  <= neg1;
            acc    <= 128'd0;
            mcand  <= {64'd0, mag1};
            mplier <= mag2;
            rem_q  <= 64'd0;
            // 32-bit dividends start at the top so the quotient lands in [31:0]
            quo_q  <= a_w ? {mag1[31:0], 32'd0} : mag1;
            dsor   <= mag2;
            if (special) out_result <= spec_result;
        end else if (state == CALC && !flush) begin
            cnt    <= cnt - 6'd1;
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            if (cnt == 6'd0) out_result <= final_result;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_op;
    logic [63:0] in_src1, in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_seq #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input int idx, input logic [63:0] a, input logic [63:0] b);
        in_op = 13'd1 << idx; in_src1 = a; in_src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 13'h1FFF;
        in_src1  = {$urandom, $urandom};
        in_src2  = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input int idx, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        start_op(idx, a, b);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check(tag, out_result, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle after"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int rose;
        logic [63:0] held;
        rst = 1'b1; in_valid = 1'b0; in_op = 13'd0; in_src1 = 64'd0; in_src2 = 64'd0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset out_result", out_result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("divu 100/7", 6, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu 100%7", 8, 64'd100, 64'd7, 64'd2, 65);
        run_op("rem -7%2", 7, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div 5/0", 5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("divw ovf", 9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("rem ovf", 7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("remuw by 0", 12, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0001, 1);
        run_op("mulh -1*-1", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
        run_op("mulhu max*max", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("mulhsu -1*2", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("mulw", 4, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("divw -7/2", 9, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("divuw", 10, 64'hAAAA_AAAA_FFFF_FFFE, 64'h5555_5555_0000_0001,
               64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("mul big", 0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0005,
               64'h0000_0005_0000_000F, 65);

        in_op = 13'b0_0000_0000_0011; in_valid = 1'b1;
        @(posedge clk); #1;
        check("two-hot ignored", {63'd0, in_ready}, 64'd1);
        in_op = 13'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("zero-hot ignored", {63'd0, busy}, 64'd0);

        start_op(0, 64'd3, 64'd5);
        wait_done(lat);
        check("bp mul result", out_result, 64'd15);
        held = out_result;
        for (int i = 0; i < 10; i++) begin
            in_op = 13'd1 << 6; in_src1 = 64'd9; in_src2 = 64'd2; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp result stable", out_result, held);
            check("bp busy", {63'd0, busy}, 64'd1);
            check("bp not ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        check("bp still done", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp consumed", {63'd0, busy}, 64'd0);

        start_op(5, 64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush idle", {63'd0, in_ready}, 64'd1);
        check("flush busy", {63'd0, busy}, 64'd0);
        rose = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        check("flush no valid", 64'(rose), 64'd0);
        run_op("mul 3*4", 0, 64'd3, 64'd4, 64'd12, 65);

        start_op(6, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst busy", {63'd0, busy}, 64'd0);
        check("async rst in_ready", {63'd0, in_ready}, 64'd1);
        check("async rst out_valid", {63'd0, out_valid}, 64'd0);
        check("async rst out_result", out_result, 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op("post-rst remu", 8, 64'd100, 64'd7, 64'd2, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the RV64M instructions (MUL/MULH/MULHSU/MULHU/MULW, DIV/DIVU/REM/REMU, DIVW/DIVUW/REMW/REMUW). Sits beside the single-cycle ALU in EX. It accepts one operation at a time from the decoded op vector, runs a 1-bit-per-cycle shift-add or restoring-divide loop, and returns a 64-bit result over a valid/ready handshake. While it works it raises `busy` so the hazard logic stalls ID/EX.

## Interface
Parameters:
- `XLEN`, 64: operand and result width. Only 64 is supported.

Ports:
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  high only in IDLE.
- `in_op`  in  13  one-hot: [0]mul [1]mulh [2]mulhsu [3]mulhu [4]mulw [5]div [6]divu [7]rem [8]remu [9]divw [10]divuw [11]remw [12]remuw.
- `in_src1`, `in_src2`  in  64  rs1 and rs2 values.
- `flush`  in  1  synchronous kill of the current operation.
- `out_valid`  out  1  result available (DONE state).
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  64  registered result.
- `busy`  out  1  high in CALC, and in DONE until the handshake completes.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on `in_valid & in_ready & ~flush`.
  - Latch op, operands and sign flags.
  - Load the iteration counter with N-1: N=64 for 64-bit ops, N=32 for *w ops.
  - Special division cases go straight to DONE with a fixed result (see Arithmetic rules).
  - Zero or multiple `in_op` bits set: the accept is ignored and the state stays IDLE.
- CALC:
  - One iteration per edge; the counter decrements each edge.
  - Counter==0 at an edge: write the final, sign-corrected result into `out_result` and go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_ready`=1: IDLE at the next edge.
  - Otherwise hold; `out_result` stays stable.
- Flush:
  - Any state goes to IDLE at the next edge; `out_valid` drops.
  - `flush` beats `in_valid` and `out_ready` in the same cycle.
- Arithmetic rules:
  - Signed operands use magnitudes internally. The sign fix (two's complement) is applied when the final result is written.
  - Multiplies build a 128-bit product by shift-add.
    - mul returns bits [63:0].
    - mulh, mulhsu and mulhu return bits [127:64].
    - For mulhsu, src1 is signed and src2 is unsigned.
  - Restoring division: quotient and remainder registers, 64 bits wide, over N steps.
  - Remainder sign follows the dividend; quotient is negative iff the operand signs differ (signed ops only).
  - *w ops:
    - Operands are the low 32 bits: sign-extended for mulw/divw/remw, zero-extended for divuw/remuw.
    - The 32-bit result is sign-extended to 64 (including divuw/remuw).
  - Divide by zero (1-cycle special case):
    - quotient = all ones (sign-extended 32 for *w).
    - remainder = dividend (per the *w rule).
  - Signed overflow (min / -1, 1-cycle special case):
    - quotient = dividend.
    - remainder = 0.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_result`=0, counter 0.
- Normal op, accepted at edge k:
  - Iterations occur at edges k+1 … k+N.
  - `out_valid` is high from the cycle after edge k+N.
  - Latency is N+1 edges: 65 for 64-bit ops, 33 for *w ops.
- Special division cases: `out_valid` is high in the cycle right after the accept edge (latency 1).
- Consuming the result: if `out_valid & out_ready` is high at edge j, the block is IDLE after j and `in_ready`=1 in that cycle.
  - No back-to-back accept in DONE: minimum spacing between accepts is latency+1 edges.
- Reset asserted mid-CALC or in DONE: immediate return to the reset values; no partial result is ever presented.
- `in_src*` and `in_op` are sampled only at the accept edge; later changes have no effect.

## Test plan
- divu 100, 7:
  - `out_result`=14 with `out_valid` rising exactly 65 edges after the accept.
  - Then remu on the same operands returns 2.
- rem -7, 2 → 0xFFFF_FFFF_FFFF_FFFF (-1).
- Special division cases:
  - div 5, 0 → all ones.
  - divw 0x8000_0000, 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000, with latency 1.
  - rem 0x8000…0, -1 → 0.
- Multiply results:
  - mulh -1, -1 → 0.
  - mulhu 0xFFFF…F, 0xFFFF…F → 0xFFFF…FFFE.
  - mulw 0x7FFF_FFFF, 2 → 0xFFFF_FFFF_FFFF_FFFE, latency 33.
- Back-pressure:
  - Hold `out_ready`=0 for 10 cycles in DONE: `out_result` and `busy` stay stable.
  - `in_valid` asserted meanwhile is not accepted.
- Flush and reset:
  - Assert `flush` at cycle 20 of a div: state is IDLE next edge and `out_valid` never rises.
  - A new mul 3, 4 then returns 12.
  - Async `rst` pulse mid-CALC: all outputs return to reset values without waiting for a clock edge.
